// File: rtl/chase_pkg.sv
// Shared types and constants for the LED-chaser / lap-counter controller.
// The BCD helper keeps digit arithmetic in one place so it never exceeds 9.
package chase_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } chase_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_inc(input logic [3:0] digit);
        return (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Raw push-button level to single-cycle pulse: two-flop synchronizer
// followed by a rising-edge detector on the synchronized level.
module btn_edge (
    input  logic hz100,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/chase_lap_ctrl.sv
// Start/stop/clear sequencer for the fill-style LED chain and the two-digit
// BCD lap counter, all on the single hz100 clock.
module chase_lap_ctrl
    import chase_pkg::*;
#(
    parameter int CHAIN_LEN = 17,
    parameter int DIV       = 1
) (
    input  logic                 hz100,
    input  logic                 reset,
    input  logic                 go_btn,
    input  logic                 clr_btn,
    output logic [CHAIN_LEN-1:0] chain,
    output logic [3:0]           ones,
    output logic [3:0]           tens,
    output logic                 tens_en,
    output logic                 running,
    output logic                 wrap
);

    localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_END = PW'(DIV - 1);

    chase_state_t  state;
    logic [PW-1:0] presc;
    logic          go_p;
    logic          clr_p;
    logic          step;

    btn_edge u_go_edge (
        .hz100 (hz100),
        .reset (reset),
        .raw   (go_btn),
        .pulse (go_p)
    );

    btn_edge u_clr_edge (
        .hz100 (hz100),
        .reset (reset),
        .raw   (clr_btn),
        .pulse (clr_p)
    );

    assign step = (state == RUN) && (presc == PRESC_END);

    // Clear overrides everything, including a simultaneous go press.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state <= STOP;
            presc <= '0;
            chain <= '0;
            ones  <= 4'd0;
            tens  <= 4'd0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr_p) begin
                state <= STOP;
                presc <= '0;
                chain <= '0;
                ones  <= 4'd0;
                tens  <= 4'd0;
            end else begin
                if (go_p) begin
                    state <= (state == RUN) ? STOP : RUN;
                end
                if (step) begin
                    presc <= '0;
                    if (!chain[CHAIN_LEN-1]) begin
                        chain <= {chain[CHAIN_LEN-2:0], 1'b1};
                    end else begin
                        chain <= '0;
                        ones  <= bcd_inc(ones);
                        if (ones == BCD_MAX) begin
                            tens <= bcd_inc(tens);
                            if (tens == BCD_MAX) begin
                                wrap <= 1'b1;
                            end
                        end
                    end
                end else if (state == RUN) begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign running = (state == RUN);
    assign tens_en = (tens != 4'd0);

endmodule

// File: tb/tb_chase_lap_ctrl.sv
// Randomized bench for chase_lap_ctrl: two instances (DIV=1 and DIV=4) share
// the buttons and are compared every cycle against a fill-level/lap-count model.
module tb_chase_lap_ctrl;

    localparam int CL = 17;

    logic          hz100;
    logic          reset;
    logic          go_btn;
    logic          clr_btn;
    logic [CL-1:0] chain_o   [2];
    logic [3:0]    ones_o    [2];
    logic [3:0]    tens_o    [2];
    logic          tens_en_o [2];
    logic          running_o [2];
    logic          wrap_o    [2];

    int errors = 0;
    int checks = 0;

    chase_lap_ctrl #(.CHAIN_LEN(CL), .DIV(1)) u_dut1 (
        .hz100(hz100), .reset(reset), .go_btn(go_btn), .clr_btn(clr_btn),
        .chain(chain_o[0]), .ones(ones_o[0]), .tens(tens_o[0]),
        .tens_en(tens_en_o[0]), .running(running_o[0]), .wrap(wrap_o[0])
    );

    chase_lap_ctrl #(.CHAIN_LEN(CL), .DIV(4)) u_dut4 (
        .hz100(hz100), .reset(reset), .go_btn(go_btn), .clr_btn(clr_btn),
        .chain(chain_o[1]), .ones(ones_o[1]), .tens(tens_o[1]),
        .tens_en(tens_en_o[1]), .running(running_o[1]), .wrap(wrap_o[1])
    );

    initial begin
        hz100 = 1'b0;
        forever #5 hz100 = ~hz100;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [CL-1:0] fill_pat(input int f);
        logic [31:0] v;
        v = (f == 0) ? 32'd0 : ((32'd1 << f) - 32'd1);
        return v[CL-1:0];
    endfunction

    // Model: button level history, run flag, prescaler, fill level, lap count.
    logic [3:0] gh;
    logic [3:0] ch;
    bit         run_m  [2];
    bit         wrap_m [2];
    int         presc_m[2];
    int         fill_m [2];
    int         laps_m [2];

    always @(posedge hz100 or posedge reset) begin : model
        bit gp, cp, st;
        if (reset) begin
            gh <= '0;
            ch <= '0;
            for (int d = 0; d < 2; d++) begin
                run_m[d]   <= 1'b0;
                wrap_m[d]  <= 1'b0;
                presc_m[d] <= 0;
                fill_m[d]  <= 0;
                laps_m[d]  <= 0;
            end
        end else begin
            gp = gh[1] && !gh[2];
            cp = ch[1] && !ch[2];
            gh <= {gh[2:0], go_btn};
            ch <= {ch[2:0], clr_btn};
            for (int d = 0; d < 2; d++) begin
                st = run_m[d] && (presc_m[d] == div_of(d) - 1);
                wrap_m[d] <= 1'b0;
                if (cp) begin
                    run_m[d]   <= 1'b0;
                    presc_m[d] <= 0;
                    fill_m[d]  <= 0;
                    laps_m[d]  <= 0;
                end else begin
                    if (gp) run_m[d] <= !run_m[d];
                    if (st) begin
                        presc_m[d] <= 0;
                        if (fill_m[d] == CL) begin
                            fill_m[d] <= 0;
                            if (laps_m[d] == 99) begin
                                laps_m[d] <= 0;
                                wrap_m[d] <= 1'b1;
                            end else begin
                                laps_m[d] <= laps_m[d] + 1;
                            end
                        end else begin
                            fill_m[d] <= fill_m[d] + 1;
                        end
                    end else if (run_m[d]) begin
                        presc_m[d] <= presc_m[d] + 1;
                    end
                end
            end
        end
    end

    always @(negedge hz100) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("chain%0d", d),   32'(chain_o[d]),   32'(fill_pat(fill_m[d])));
                check($sformatf("ones%0d", d),    32'(ones_o[d]),    32'(laps_m[d] % 10));
                check($sformatf("tens%0d", d),    32'(tens_o[d]),    32'(laps_m[d] / 10));
                check($sformatf("tens_en%0d", d), 32'(tens_en_o[d]), 32'(laps_m[d] >= 10));
                check($sformatf("running%0d", d), 32'(running_o[d]), 32'(run_m[d]));
                check($sformatf("wrap%0d", d),    32'(wrap_o[d]),    32'(wrap_m[d]));
            end
        end
    end

    task automatic press(input bit use_go, input bit use_clr, input int hold);
        if (use_go)  go_btn  = 1'b1;
        if (use_clr) clr_btn = 1'b1;
        repeat (hold) @(negedge hz100);
        go_btn  = 1'b0;
        clr_btn = 1'b0;
        repeat (3) @(negedge hz100);
    endtask

    initial begin
        int  e;
        bit  found;
        bit  seen10;
        reset   = 1'b1;
        go_btn  = 1'b0;
        clr_btn = 1'b0;
        repeat (2) @(negedge hz100);
        check("rst_chain",   32'(chain_o[0]),   32'h0);
        check("rst_running", 32'(running_o[0]), 32'h0);
        check("rst_tens_en", 32'(tens_en_o[1]), 32'h0);
        reset = 1'b0;

        // Start: go held for 5 edges; hand-computed timeline pins the model.
        @(negedge hz100);
        go_btn = 1'b1;
        e = 0;
        repeat (21) begin
            @(negedge hz100);
            e++;
            if (e == 5) go_btn = 1'b0;
            case (e)
                2:  check("start_running_e2", 32'(running_o[0]), 32'h0);
                3:  begin
                        check("start_running_e3", 32'(running_o[0]), 32'h1);
                        check("start_chain_e3",   32'(chain_o[0]),   32'h0);
                    end
                4:  check("start_chain_e4",  32'(chain_o[0]), 32'h00001);
                6:  check("div4_chain_e6",   32'(chain_o[1]), 32'h0);
                7:  check("div4_chain_e7",   32'(chain_o[1]), 32'h1);
                20: check("lap_full_e20",    32'(chain_o[0]), 32'h1FFFF);
                21: begin
                        check("lap_zero_e21",  32'(chain_o[0]),   32'h0);
                        check("lap_ones_e21",  32'(ones_o[0]),    32'h1);
                        check("div4_chain_e21", 32'(chain_o[1]),  32'hF);
                        check("still_running", 32'(running_o[0]), 32'h1);
                    end
                default: ;
            endcase
        end

        // Random button activity, including simultaneous go/clr presses.
        repeat (60) begin
            case ($urandom_range(0, 5))
                0, 1:    press(1'b1, 1'b0, $urandom_range(1, 5));
                2:       press(1'b0, 1'b1, $urandom_range(1, 4));
                3:       press(1'b1, 1'b1, $urandom_range(1, 3));
                default: repeat ($urandom_range(1, 40)) @(negedge hz100);
            endcase
        end

        // 100 laps from a cleared, running state: 09->10 carry, then 99->00 wrap.
        press(1'b0, 1'b1, 2);
        press(1'b1, 1'b0, 2);
        found  = 1'b0;
        seen10 = 1'b0;
        for (int i = 0; i < 2500 && !found; i++) begin
            @(negedge hz100);
            if (tens_o[0] == 4'd1 && !seen10) begin
                seen10 = 1'b1;
                check("carry_ones",    32'(ones_o[0]),    32'h0);
                check("carry_tens_en", 32'(tens_en_o[0]), 32'h1);
            end
            if (wrap_o[0]) found = 1'b1;
        end
        check("carry_seen", 32'(seen10), 32'h1);
        if (found) begin
            check("wrap_ones",    32'(ones_o[0]),    32'h0);
            check("wrap_tens",    32'(tens_o[0]),    32'h0);
            check("wrap_tens_en", 32'(tens_en_o[0]), 32'h0);
            @(negedge hz100);
            check("wrap_one_cycle", 32'(wrap_o[0]), 32'h0);
        end else begin
            check("wrap_timeout", 32'h0, 32'h1);
        end

        // Clear and go together while running: clear must win.
        repeat (30) @(negedge hz100);
        go_btn  = 1'b1;
        clr_btn = 1'b1;
        repeat (3) @(negedge hz100);
        check("prio_running", 32'(running_o[0]), 32'h0);
        check("prio_chain",   32'(chain_o[0]),   32'h0);
        check("prio_ones",    32'(ones_o[0]),    32'h0);
        check("prio_running4", 32'(running_o[1]), 32'h0);
        go_btn  = 1'b0;
        clr_btn = 1'b0;
        repeat (3) @(negedge hz100);

        // Asynchronous reset between edges while running.
        press(1'b1, 1'b0, 2);
        repeat (10) @(negedge hz100);
        #2 reset = 1'b1;
        #1;
        check("arst_running", 32'(running_o[0]), 32'h0);
        check("arst_chain",   32'(chain_o[0]),   32'h0);
        check("arst_chain4",  32'(chain_o[1]),   32'h0);
        @(negedge hz100);
        reset = 1'b0;
        repeat (5) @(negedge hz100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chase_lap_ctrl.md
# chase_lap_ctrl

Sequencing controller for the LED-chaser / two-digit lap-counter datapath on the lab board. It takes raw push-button levels and the 100 Hz board clock. It runs a start/stop/clear state machine and a step prescaler, advances a fill-style LED chain, and counts completed chain laps in BCD (00–99). It drives the chain LEDs and the two digit values plus a tens-blank enable for the existing seven-segment decoders. The block replaces per-button clocking and ripple-clocked counters with a single-clock design.

## Interface
- `CHAIN_LEN`, default 17: number of LEDs in the chain (≥2).
- `DIV`, default 1: hz100 cycles per chain step (≥1).
- `hz100`  input  1  system clock; all flops on posedge.
- `reset`  input  1  asynchronous, active-high reset.
- `go_btn`  input  1  raw start/stop button level, asynchronous to hz100.
- `clr_btn`  input  1  raw clear button level, asynchronous to hz100.
- `chain`  output  CHAIN_LEN  LED chain pattern; bit 0 fills first.
- `ones`  output  4  lap count ones digit, BCD.
- `tens`  output  4  lap count tens digit, BCD.
- `tens_en`  output  1  high when `tens` ≠ 0; used for leading-zero blanking.
- `running`  output  1  high in RUN state.
- `wrap`  output  1  one-cycle pulse when the lap count rolls 99→00.

## Operation
- Each button passes through a 2-flop synchronizer and then a previous-value flop.
- `go_p` = sync2 & ~prev for `go_btn`; `clr_p` is formed the same way for `clr_btn`.
- States are STOP and RUN; reset enters STOP.
- In STOP, `go_p` moves to RUN. In RUN, `go_p` moves to STOP.
- `clr_p` in either state: go to STOP, set chain to 0, set ones and tens to 0, set the prescaler to 0.
- `clr_p` and `go_p` in the same cycle: `clr_p` wins, and `go_p` is discarded.
- Prescaler counts 0..DIV-1 only in RUN and holds its value in STOP.
- `step` = RUN & (presc == DIV-1). On `step` the prescaler returns to 0.
- Chain step rules:
  - chain[CHAIN_LEN-1] == 0: chain ← {chain[CHAIN_LEN-2:0], 1'b1}.
  - otherwise: chain ← 0 and the lap count increments.
- One lap is CHAIN_LEN+1 steps, from all-zero through all-ones and back to zero.
- Lap increment rules:
  - ones < 9: ones+1.
  - ones == 9: ones ← 0 and tens+1.
  - tens == 9 and ones == 9: both ← 0, and `wrap` pulses for that one cycle.
- Digits never hold values above 9.
- `tens_en` is combinational: (tens != 0).

## Timing
- Reset values: chain 0, ones 0, tens 0, tens_en 0, running 0, wrap 0, prescaler 0.
- All synchronizer and edge flops reset to 0.
- A button level that is high at a given edge N produces:
  - sync1 at N, sync2 at N+1;
  - the pulse during the cycle after N+1;
  - the state or clear effect visible after edge N+2.
- A held button produces exactly one pulse. Release produces no pulse.
- The first step after entering RUN (presc=0) takes effect DIV edges later. With DIV=1, chain = 1 one edge after `running` rises.
- The chain, lap counter and `wrap` update on the same edge as `step`.
- `wrap` is registered: high for exactly one cycle, coincident with tens/ones becoming 00.
- Stop mid-lap: chain, digits and prescaler freeze. Resume continues from the frozen values with no skipped or repeated step.
- Asynchronous reset mid-operation returns all outputs to reset values immediately. Operation restarts in STOP.

## Structure
- Package `chase_pkg`:
  - state enum `chase_state_t` {STOP, RUN};
  - localparam `BCD_MAX = 4'd9`.
- Sub-module `btn_edge`: inputs hz100, reset, raw; output one-cycle `pulse` (2-flop synchronizer plus rising-edge detect). Instantiate it twice, for go and clr.
- Prescaler, chain and BCD logic are inline in `chase_lap_ctrl`. Digit decoding stays in the existing seven-segment decoder, outside this block.

## Test plan
- **Reset and start:** reset pulse, then go_btn high for 5 cycles.
  - All outputs 0 after reset.
  - `running` = 1 after the 3rd edge and stays 1; exactly one toggle.
- **Full lap:** DIV=1, CHAIN_LEN=17, RUN.
  - chain goes 0x00001, 0x00003, … 0x1FFFF, then 0x00000.
  - ones = 1 exactly 18 steps after start.
- **Prescaler:** DIV=4.
  - chain changes every 4th cycle only.
  - Stop after 6 cycles, wait 20 cycles, restart: the next change arrives 2 RUN cycles later (presc held at 2).
- **BCD carry and wrap:** run 99 laps, then one more.
  - Passes through 09 → 10 (tens_en rises).
  - 99 → 00 with `wrap` high for exactly one cycle; tens_en falls.
- **Clear priority:** go_btn and clr_btn rise on the same cycle while in RUN at lap 37.
  - Result: STOP, chain 0, digits 00, `running` 0.
- **Async reset:** assert reset between clock edges during RUN.
  - Outputs go to 0 before the next hz100 edge.
